// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns a valid/ready command stream into single APB transfers
// and returns read data / error status on a valid/ready response stream.
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready high
// SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// ACCESS | PSEL=PENABLE=1 until PREADY or wait-state timeout
// RESP   | response held until consumer takes it
module apb_cmd_master #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Qualify with PRESETn so no command is accepted while reset is held.
    assign cmd_ready   = (state == IDLE) && PRESETn;
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PADDR  <= cmd_addr;
                        PWRITE <= cmd_write;
                        PWDATA <= cmd_write ? cmd_wdata : 32'h0;
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        PWRITE      <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        // Hung slave: abandon the transfer and report it.
                        rsp_rdata   <= 32'h0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        PWRITE      <= 1'b0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: a vector table of single transfers plus
// hand-written sequences for back-to-back commands and mid-transfer reset.
module tb_apb_cmd_master;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic              PCLK_TB;
    logic              PRESETn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int n_cmp = 0;
    int n_bad = 0;

    apb_cmd_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .PCLK        (PCLK_TB),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK_TB = 1'b0;
    always #5 PCLK_TB = ~PCLK_TB;

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [31:0]       prdata;
        int                waits;      // ACCESS cycles with PREADY low before it rises
        logic              err_in;     // PSLVERR on the completing cycle
        logic              setup_rdy;  // PREADY value during SETUP
        int                hold;       // cycles rsp_ready stays low in RESP
        logic [31:0]       exp_rdata;
        logic              exp_err;
        logic              exp_to;
        int                exp_lat;    // handshake edge to first rsp_valid cycle
        int                exp_acc;    // number of ACCESS cycles
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK_TB);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         lat;
        int         acc;
        bit         stable_ok;
        bit         hold_ok;
        logic [31:0] exp_wd;
        exp_wd    = v.write ? v.wdata : 32'h0;
        stable_ok = 1'b1;
        hold_ok   = 1'b1;
        @(negedge PCLK_TB);
        chk($sformatf("v%0d cmd_ready idle", idx), {31'b0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        // SETUP cycle: slave signals carry junk that must be ignored
        PREADY  = v.setup_rdy;
        PSLVERR = 1'b1;
        PRDATA  = 32'hFFFF_FFFF;
        chk($sformatf("v%0d setup psel/pen", idx), {30'b0, PSEL, PENABLE}, 32'h2);
        chk($sformatf("v%0d setup paddr", idx), 32'(PADDR), 32'(v.addr));
        chk($sformatf("v%0d setup pwdata", idx), PWDATA, exp_wd);
        lat = 1;
        acc = 0;
        forever begin
            tick();
            lat++;
            if (rsp_valid === 1'b1 || lat > 40) break;
            if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== v.addr ||
                PWDATA !== exp_wd || PWRITE !== v.write)
                stable_ok = 1'b0;
            PREADY  = (acc >= v.waits);
            PSLVERR = PREADY ? v.err_in : 1'b1;
            PRDATA  = PREADY ? v.prdata : 32'hFFFF_FFFF;
            acc++;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d access cycles", idx), 32'(acc), 32'(v.exp_acc));
        chk($sformatf("v%0d access stable", idx), {31'b0, stable_ok}, 32'h1);
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d rsp_err/to", idx), {30'b0, rsp_err, rsp_timeout},
            {30'b0, v.exp_err, v.exp_to});
        chk($sformatf("v%0d bus idle", idx), {29'b0, PSEL, PENABLE, PWRITE}, 32'h0);
        chk($sformatf("v%0d pwdata kept", idx), PWDATA, exp_wd);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_rdata !== v.exp_rdata || rsp_err !== v.exp_err ||
                rsp_timeout !== v.exp_to || cmd_ready !== 1'b0 || PSEL !== 1'b0)
                hold_ok = 1'b0;
        end
        if (v.hold > 0)
            chk($sformatf("v%0d rsp held", idx), {31'b0, hold_ok}, 32'h1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk($sformatf("v%0d after rsp", idx), {30'b0, rsp_valid, cmd_ready}, 32'h1);
    endtask

    initial begin
        int lat;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        //            wr    addr     wdata          prdata         w   err   srdy  hold  exp_rdata      err   to    lat acc
        vecs[0] = '{1'b1, 10'h300, 32'h1ACCE551, 32'h0,         0,  1'b0, 1'b0, 0, 32'h0,         1'b0, 1'b0, 3,  1};
        vecs[1] = '{1'b0, 10'h000, 32'h0,        32'h00000032,  0,  1'b0, 1'b0, 0, 32'h00000032,  1'b0, 1'b0, 3,  1};
        vecs[2] = '{1'b1, 10'h155, 32'hDEADBEEF, 32'h0,         3,  1'b0, 1'b0, 0, 32'h0,         1'b0, 1'b0, 6,  4};
        vecs[3] = '{1'b0, 10'h2AA, 32'h0,        32'hCAFEF00D,  0,  1'b1, 1'b0, 5, 32'hCAFEF00D,  1'b1, 1'b0, 3,  1};
        vecs[4] = '{1'b0, 10'h3FF, 32'h0,        32'h12345678,  99, 1'b0, 1'b0, 2, 32'h0,         1'b1, 1'b1, 18, 16};
        vecs[5] = '{1'b1, 10'h001, 32'hA5A5A5A5, 32'h0,         2,  1'b0, 1'b1, 0, 32'h0,         1'b0, 1'b0, 5,  3};
        vecs[6] = '{1'b0, 10'h0F0, 32'h0,        32'h0BADF00D,  15, 1'b0, 1'b0, 0, 32'h0BADF00D,  1'b0, 1'b0, 18, 16};
        vecs[7] = '{1'b1, 10'h042, 32'h5555AAAA, 32'h0,         1,  1'b1, 1'b0, 0, 32'h0,         1'b1, 1'b0, 4,  2};

        #12;
        chk("reset cmd_ready", {31'b0, cmd_ready}, 32'h0);
        chk("reset bus", {29'b0, PSEL, PENABLE, PWRITE}, 32'h0);
        chk("reset rsp", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'h0);
        chk("reset paddr/pwdata", PWDATA | 32'(PADDR), 32'h0);
        @(negedge PCLK_TB);
        PRESETn = 1'b1;
        tick();
        chk("post-reset cmd_ready", {31'b0, cmd_ready}, 32'h1);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Command offered while the previous response is still pending
        @(negedge PCLK_TB);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h0AB; cmd_wdata = 32'h11112222;
        tick();
        cmd_write = 1'b0; cmd_addr = 10'h044; cmd_wdata = 32'h99999999;
        PREADY = 1'b1;
        tick();
        tick();
        chk("b2b rsp_valid", {31'b0, rsp_valid}, 32'h1);
        PREADY = 1'b0;
        for (int h = 0; h < 3; h++) begin
            tick();
            chk($sformatf("b2b wait%0d psel/cmd_ready", h), {30'b0, PSEL, cmd_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("b2b idle", {30'b0, rsp_valid, cmd_ready}, 32'h1);
        tick();
        cmd_valid = 1'b0;
        chk("b2b second setup", {30'b0, PSEL, PENABLE}, 32'h2);
        chk("b2b second paddr", 32'(PADDR), 32'h044);
        chk("b2b second pwdata", PWDATA, 32'h0);
        PREADY = 1'b1; PRDATA = 32'h00000077;
        tick();
        tick();
        PREADY = 1'b0;
        chk("b2b second rdata", rsp_rdata, 32'h00000077);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset pulse while in ACCESS with a stalled slave
        @(negedge PCLK_TB);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h123; cmd_wdata = 32'hFEEDFACE;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst pre access", {30'b0, PSEL, PENABLE}, 32'h3);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("rst async bus", {29'b0, PSEL, PENABLE, rsp_valid}, 32'h0);
        chk("rst cmd_ready", {31'b0, cmd_ready}, 32'h0);
        chk("rst paddr", 32'(PADDR), 32'h0);
        @(negedge PCLK_TB);
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        lat = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (PSEL !== 1'b0 || rsp_valid !== 1'b0) lat++;
        end
        PREADY = 1'b0;
        chk("rst no replay", 32'(lat), 32'h0);
        chk("rst idle ready", {31'b0, cmd_ready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
